up_dn_cntr_sweep_ctrl: RTL and testbench

Sequencer for the 4-bit up/down counter with load and start/stop. On each accepted command it loads a start value and sweeps the counter up to a high bound, then down to a low bound, for a programmed number of loops. It closes the loop on the counter's `cnt` output, drives the counter's `load_en`, `load_data`, `up_dnb` and `start_stop_b` directly, and reports completion to the host-side requester.

---
 rtl/up_dn_cntr_sweep_ctrl.sv | 128 ++++++++++++
 tb/tb_up_dn_cntr_sweep_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/up_dn_cntr_sweep_ctrl.sv
// rtl/up_dn_cntr_sweep_ctrl.sv - up/down sweep sequencer closing the loop on a 4-bit counter
// Optional per-phase watchdog: define SWEEP_CTRL_TIMEOUT_EN.
module up_dn_cntr_sweep_ctrl #(
   parameter int TIMEOUT_CYCLES = 20
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_start,
   input  logic [3:0] cmd_low,
   input  logic [3:0] cmd_high,
   input  logic [3:0] cmd_loops,
   input  logic       abort,
   input  logic [3:0] cnt,
   output logic       load_en,
   output logic [3:0] load_data,
   output logic       up_dnb,
   output logic       start_stop_b,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, DONE} state_t;

   state_t     state, state_nxt;
   logic [3:0] low_r, high_r, loops_left;
   logic       accept, cmd_bad, timeout, dec_loop;

   assign accept    = cmd_valid && cmd_ready;
   assign cmd_bad   = (cmd_low >= cmd_high) || (cmd_start < cmd_low) ||
                      (cmd_start > cmd_high) || (cmd_loops == 4'd0);
   assign cmd_ready = (state == IDLE) && !abort;
   assign busy      = (state != IDLE);

`ifdef SWEEP_CTRL_TIMEOUT_EN
   logic [4:0] wdog;

   // Counts cycles spent in the current UP/DOWN phase; any state change restarts it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         wdog <= 5'd0;
      else if ((state_nxt != state) || !((state == UP) || (state == DOWN)))
         wdog <= 5'd0;
      else
         wdog <= wdog + 5'd1;
   end

   assign timeout = !abort && (wdog == 5'(TIMEOUT_CYCLES - 1)) &&
                    (((state == UP) && (cnt != high_r)) || ((state == DOWN) && (cnt != low_r)));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 16);
   assign timeout            = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         load_data  <= 4'd0;
         low_r      <= 4'd0;
         high_r     <= 4'd0;
         loops_left <= 4'd0;
         err        <= 1'b0;
      end else begin
         state <= state_nxt;
         err   <= (accept && cmd_bad) || timeout;
         if (accept) begin
            load_data  <= cmd_start;
            low_r      <= cmd_low;
            high_r     <= cmd_high;
            loops_left <= cmd_loops;
         end else if (dec_loop) begin
            loops_left <= loops_left - 4'd1;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      load_en      = 1'b0;
      up_dnb       = 1'b1;
      start_stop_b = 1'b0;
      done         = 1'b0;
      dec_loop     = 1'b0;
      case (state)
         IDLE: begin
            if (accept && !cmd_bad)
               state_nxt = LOAD;
         end
         LOAD: begin
            load_en   = 1'b1;
            state_nxt = abort ? IDLE : UP;
         end
         UP: begin
            start_stop_b = (cnt != high_r);
            if (abort || timeout)
               state_nxt = IDLE;
            else if (cnt == high_r)
               state_nxt = DOWN;
         end
         DOWN: begin
            up_dnb       = 1'b0;
            start_stop_b = (cnt != low_r);
            if (abort || timeout) begin
               state_nxt = IDLE;
            end else if (cnt == low_r) begin
               if (loops_left > 4'd1) begin
                  dec_loop  = 1'b1;
                  state_nxt = UP;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Stop the counter in the very cycle a sweep is cancelled so it holds its value.
      if (abort || timeout)
         start_stop_b = 1'b0;
   end

endmodule

// File: tb/tb_up_dn_cntr_sweep_ctrl.sv
// tb/tb_up_dn_cntr_sweep_ctrl.sv - scoreboard bench for the counter sweep sequencer
module tb_up_dn_cntr_sweep_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [3:0] cmd_start = 4'd0, cmd_low = 4'd0, cmd_high = 4'd0, cmd_loops = 4'd0;
   logic       abort = 1'b0;
   logic [3:0] cnt = 4'd0;
   logic       freeze = 1'b0;
   logic       cmd_ready, load_en, up_dnb, start_stop_b, busy, done, err;
   logic [3:0] load_data;

   int cyc = 0;
   int n_vec = 0;
   int n_bad = 0;

   typedef struct { int cyc; bit is_err; } ev_t;
   typedef struct { int cyc; bit chk_cnt; int val; bit busy; } tr_t;

   ev_t ev_q[$];
   tr_t tr_q[$];

   up_dn_cntr_sweep_ctrl #(.TIMEOUT_CYCLES(20)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_start(cmd_start), .cmd_low(cmd_low), .cmd_high(cmd_high), .cmd_loops(cmd_loops),
      .abort(abort), .cnt(cnt),
      .load_en(load_en), .load_data(load_data), .up_dnb(up_dnb), .start_stop_b(start_stop_b),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Counter being sequenced; freeze models a stuck counter.
   always @(posedge clk) begin
      if (load_en)
         cnt <= load_data;
      else if (start_stop_b && !freeze)
         cnt <= up_dnb ? cnt + 4'd1 : cnt - 4'd1;
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: expected cnt trace and completion cycle derived from the sweep rules.
   task automatic model_push(input int s, input int l, input int h, input int n, input int a);
      int vals[$];
      int nd;
      if (l >= h || s < l || s > h || n == 0) begin
         ev_q.push_back('{a + 1, 1'b1});
         tr_q.push_back('{a + 1, 1'b0, 0, 1'b0});
      end else begin
         for (int v = s; v <= h; v++) vals.push_back(v);
         for (int k = 0; k < n; k++) begin
            if (k > 0) for (int v = l; v <= h; v++) vals.push_back(v);
            for (int v = h; v >= l; v--) vals.push_back(v);
         end
         nd = 2 + vals.size();
         tr_q.push_back('{a + 1, 1'b0, 0, 1'b1});
         for (int i = 0; i < vals.size(); i++) tr_q.push_back('{a + 2 + i, 1'b1, vals[i], 1'b1});
         tr_q.push_back('{a + nd, 1'b0, 0, 1'b1});
         tr_q.push_back('{a + nd + 1, 1'b0, 0, 1'b0});
         ev_q.push_back('{a + nd, 1'b0});
      end
   endtask

   // Monitor: compares DUT against queued expectations, independent of the driver.
   always @(negedge clk) begin
      tr_t t;
      ev_t e;
      if (reset_n) begin
         if (tr_q.size() > 0 && tr_q[0].cyc == cyc) begin
            t = tr_q.pop_front();
            check("busy", int'(busy), int'(t.busy));
            if (t.chk_cnt) check("cnt", int'(cnt), t.val);
         end
         if (done || err) begin
            if (ev_q.size() == 0) begin
               check(done ? "pending event for done" : "pending event for err", ev_q.size(), 1);
            end else begin
               e = ev_q.pop_front();
               check("event is err", int'(err), int'(e.is_err));
               check("event cycle", cyc, e.cyc);
            end
         end
      end
   end

   task automatic send_cmd(input int s, input int l, input int h, input int n,
                           input bit track, output int acc);
      int k = 0;
      @(negedge clk);
      cmd_start = 4'(s); cmd_low = 4'(l); cmd_high = 4'(h); cmd_loops = 4'(n);
      cmd_valid = 1'b1;
      while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
      check("cmd_ready at issue", int'(cmd_ready), 1);
      acc = cyc;
      if (track) model_push(s, l, h, n, acc);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      @(negedge clk);
      while (busy && k < 2000) begin @(negedge clk); k++; end
      check("return to idle", int'(busy), 0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " load_en"}, int'(load_en), 0);
      check({tag, " load_data"}, int'(load_data), 0);
      check({tag, " up_dnb"}, int'(up_dnb), 1);
      check({tag, " start_stop_b"}, int'(start_stop_b), 0);
      check({tag, " busy"}, int'(busy), 0);
      check({tag, " done"}, int'(done), 0);
      check({tag, " err"}, int'(err), 0);
      check({tag, " cmd_ready"}, int'(cmd_ready), 1);
   endtask

   initial begin
      int a;
      int l, h, s, n;
      #1;
      check_reset_vals("reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      send_cmd(3, 2, 5, 1, 1'b1, a);  wait_idle();
      send_cmd(2, 2, 4, 3, 1'b1, a);  wait_idle();
      send_cmd(5, 2, 5, 1, 1'b1, a);  wait_idle();
      send_cmd(0, 0, 15, 15, 1'b1, a); wait_idle();
      send_cmd(2, 2, 3, 2, 1'b1, a);  wait_idle();

      send_cmd(5, 5, 5, 1, 1'b1, a);
      check("reject load_en", int'(load_en), 0);
      wait_idle();
      send_cmd(9, 2, 6, 1, 1'b1, a);  wait_idle();
      send_cmd(3, 2, 5, 0, 1'b1, a);  wait_idle();
      send_cmd(1, 2, 5, 1, 1'b1, a);  wait_idle();

      send_cmd(3, 2, 7, 1, 1'b0, a);
      while (cyc != a + 3) @(negedge clk);
      check("abort cnt before", int'(cnt), 4);
      abort = 1'b1;
      #1;
      check("abort start_stop_b", int'(start_stop_b), 0);
      check("abort cmd_ready busy", int'(cmd_ready), 0);
      @(negedge clk);
      check("abort cnt hold", int'(cnt), 4);
      check("abort busy", int'(busy), 0);
      check("abort cmd_ready held", int'(cmd_ready), 0);
      abort = 1'b0;
      #1;
      check("abort cmd_ready after", int'(cmd_ready), 1);

      send_cmd(3, 2, 5, 1, 1'b1, a);
      while (cyc != a + 6) @(negedge clk);
      #2;
      ev_q.delete();
      tr_q.delete();
      reset_n = 1'b0;
      #1;
      check_reset_vals("midsweep reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      send_cmd(3, 2, 5, 1, 1'b1, a);  wait_idle();

      freeze = 1'b1;
      send_cmd(3, 1, 7, 1, 1'b0, a);
`ifdef SWEEP_CTRL_TIMEOUT_EN
      ev_q.push_back('{a + 22, 1'b1});
      tr_q.push_back('{a + 22, 1'b0, 0, 1'b0});
      wait_idle();
`else
      while (cyc != a + 40) @(negedge clk);
      check("stuck busy", int'(busy), 1);
      check("stuck start_stop_b", int'(start_stop_b), 1);
      check("stuck cnt", int'(cnt), 3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("stuck abort idle", int'(busy), 0);
`endif
      freeze = 1'b0;

      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 4) != 0) begin
            l = $urandom_range(0, 14);
            h = $urandom_range(l + 1, 15);
            s = $urandom_range(l, h);
            n = $urandom_range(1, 3);
         end else begin
            l = $urandom_range(0, 15);
            h = $urandom_range(0, 15);
            s = $urandom_range(0, 15);
            n = $urandom_range(0, 2);
         end
         send_cmd(s, l, h, n, 1'b1, a);
         wait_idle();
      end

      repeat (4) @(negedge clk);
      check("events outstanding", ev_q.size(), 0);
      check("trace outstanding", tr_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
